concat_rep_pipe: RTL and testbench
==================================

// Module: concat_rep_pipe
// PURPOSE
//   Registered, parametrised successor to the 4-bit concat/replicate/conditional operator block.
//   Applies one of four bit-assembly modes to W-bit operands:
//     CONCAT, REPLICATE, SELECT, and PACK (multi-beat concatenation).
//   Results are delivered over a valid/ready stream.
//   Sits between operand sources and downstream word consumers in the lab datapath.
// PARAMETERS
//   W      4   operand width in bits (>=1)
//   REP    4   replication factor and PACK beat count (>=2)
//   OUT_W  W*REP   result width; derived localparam, not overridable
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous active-low reset
//   in_valid    in   1      operand beat valid
//   in_ready    out  1      block accepts beat this cycle
//   mode        in   2      00 CONCAT, 01 REPLICATE, 10 SELECT, 11 PACK
//   in1         in   W      operand 1
//   in2         in   W      operand 2
//   sel         in   1      SELECT control
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts result
//   out_data    out  OUT_W  result
//   out_mode    out  2      mode that produced out_data
//   pack_abort  out  1      1-cycle pulse: partial PACK discarded
// BEHAVIOUR
//   Reset (rst_n low at posedge): out_valid=0, out_data=0, out_mode=00, pack_abort=0.
//     Pack accumulator and pack_cnt are cleared.
//     Reset mid-PACK discards the partial word; no pack_abort is raised.
//   Handshake: in_ready = !out_valid | out_ready (combinational). A beat is accepted when in_valid & in_ready.
//   Output register:
//     Set on an accepted result-producing beat.
//     Cleared on out_valid & out_ready with no new result.
//     Accept and consume in the same cycle loads the new result, so throughput is 1 beat/cycle.
//   Latency: out_valid rises on the posedge that accepts the producing beat, i.e. result visible 1 cycle after acceptance.
//   out_data/out_mode are held stable while out_valid & !out_ready.
//   CONCAT:    out_data = {in1,in2} in the low 2W bits; upper bits 0.
//   REPLICATE: out_data = {REP{in1}}.
//   SELECT:    out_data = sel ? in1 : in2, zero-extended.
//   PACK:
//     Each accepted beat shifts the accumulator left by W and inserts in1. First beat lands in the MS slice.
//     pack_cnt counts 0..REP-1.
//     Beats 1..REP-1 produce no output.
//     Beat REP loads the full word into out_data, sets out_valid, out_mode=11, and wraps pack_cnt to 0.
//     in2 and sel are ignored.
//   Mode switch mid-PACK (accepted non-PACK beat while pack_cnt!=0):
//     Partial word discarded, pack_cnt=0, pack_abort pulses that cycle.
//     The non-PACK beat itself completes normally.
//   in_valid low: no state change. pack_cnt is held indefinitely between PACK beats.
//   Unaccepted beats (in_ready=0) have no effect on any state.
// TESTING (W=4, REP=4, out_ready=1 unless stated)
//   1. Reset then idle
//      -> out_valid=0, out_data=0x0000, in_ready=1.
//   2. CONCAT in1=1101 in2=1010; REPLICATE in1=0010
//      -> 0x00DA then 0x2222 on consecutive cycles.
//      -> out_mode 00 then 01.
//   3. SELECT sel=1 in1=0101 in2=1100 -> 0x0005; then sel=0 -> 0x000C.
//   4. PACK beats in1=1,2,3,4 back-to-back
//      -> out_valid low for the first 3 beats.
//      -> single out_data=0x1234 after the 4th beat, out_mode=11.
//   5. out_ready=0 with a result pending
//      -> in_ready=0 and out_data stable for 5 cycles, next beat not taken.
//      Raise out_ready -> result consumed and the next beat accepted that cycle.
//   6. PACK 1,2 then CONCAT 0011/1100
//      -> pack_abort=1 for 1 cycle, out_data=0x003C.
//      Following PACK 5,6,7,8 -> 0x5678.
//      Repeat with rst_n low after 2 beats -> no abort, fresh pack afterwards.

Source files
------------

// File: rtl/concat_rep_pipe.sv
// concat_rep_pipe: registered concat/replicate/select/pack on W-bit operands over valid/ready; ports clk, rst_n, in_valid/in_ready/mode/in1/in2/sel in, out_valid/out_ready/out_data/out_mode, pack_abort pulse
module concat_rep_pipe #(
  parameter int W   = 4,
  parameter int REP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [W-1:0]       in1,
  input  logic [W-1:0]       in2,
  input  logic               sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*REP-1:0]   out_data,
  output logic [1:0]         out_mode,
  output logic               pack_abort
);
  localparam int OUT_W = W * REP;
  localparam int CW = $clog2(REP);
  logic [OUT_W-1:0] pack_acc, pack_next, res;
  logic [CW-1:0] pack_cnt;
  logic acc, pk, last, produce;
  assign in_ready  = !out_valid | out_ready;
  assign acc       = in_valid & in_ready;
  assign pk        = mode == 2'b11;
  assign last      = pack_cnt == CW'(REP - 1);
  assign produce   = acc & (!pk | last);
  assign pack_next = {pack_acc[OUT_W-W-1:0], in1};
  always_comb begin
    res = mode == 2'b00 ? OUT_W'({in1, in2}) :
          mode == 2'b01 ? {REP{in1}} :
          mode == 2'b10 ? OUT_W'(sel ? in1 : in2) : pack_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= 2'b00;
      pack_abort <= 1'b0;
      pack_acc   <= '0;
      pack_cnt   <= '0;
    end else begin
      pack_abort <= acc & !pk & (pack_cnt != '0);
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_mode  <= mode;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc) begin
        pack_cnt <= (pk & !last) ? pack_cnt + CW'(1) : '0;
        pack_acc <= (pk & !last) ? pack_next : '0;
      end
    end
  end
endmodule

// File: tb/tb_concat_rep_pipe.sv
// tb_concat_rep_pipe: table-driven and directed self-checking bench for concat_rep_pipe
module tb_concat_rep_pipe;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, sel, out_valid, out_ready, pack_abort;
  logic [1:0] mode, out_mode;
  logic [3:0] in1, in2;
  logic [15:0] out_data;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic v; logic [1:0] m; logic [3:0] a; logic [3:0] b; logic s;
    logic ev; logic [15:0] ed; logic [1:0] em; logic ea;
  } vec_t;
  vec_t tv[16];
  concat_rep_pipe #(.W(4), .REP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in1(in1), .in2(in2), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .pack_abort(pack_abort)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [1:0] m, input logic [3:0] a,
                      input logic [3:0] b, input logic s);
    in_valid = v; mode = m; in1 = a; in2 = b; sel = s;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    tv[0]  = '{1'b1, 2'd0, 4'hD, 4'hA, 1'b0, 1'b1, 16'h00DA, 2'd0, 1'b0};
    tv[1]  = '{1'b1, 2'd1, 4'h2, 4'h0, 1'b0, 1'b1, 16'h2222, 2'd1, 1'b0};
    tv[2]  = '{1'b1, 2'd2, 4'h5, 4'hC, 1'b1, 1'b1, 16'h0005, 2'd2, 1'b0};
    tv[3]  = '{1'b1, 2'd2, 4'h5, 4'hC, 1'b0, 1'b1, 16'h000C, 2'd2, 1'b0};
    tv[4]  = '{1'b1, 2'd3, 4'h1, 4'hF, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[5]  = '{1'b1, 2'd3, 4'h2, 4'hF, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[6]  = '{1'b1, 2'd3, 4'h3, 4'h0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[7]  = '{1'b1, 2'd3, 4'h4, 4'h9, 1'b0, 1'b1, 16'h1234, 2'd3, 1'b0};
    tv[8]  = '{1'b1, 2'd3, 4'h1, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[9]  = '{1'b1, 2'd3, 4'h2, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[10] = '{1'b1, 2'd0, 4'h3, 4'hC, 1'b0, 1'b1, 16'h003C, 2'd0, 1'b1};
    tv[11] = '{1'b1, 2'd3, 4'h5, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[12] = '{1'b1, 2'd3, 4'h6, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[13] = '{1'b0, 2'd0, 4'hE, 4'hE, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[14] = '{1'b1, 2'd3, 4'h7, 4'h0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tv[15] = '{1'b1, 2'd3, 4'h8, 4'h0, 1'b0, 1'b1, 16'h5678, 2'd3, 1'b0};
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; mode = 2'd0; in1 = 4'h0; in2 = 4'h0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_out_mode", 32'(out_mode), 32'd0);
    chk("reset_pack_abort", 32'(pack_abort), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_out_data", 32'(out_data), 32'h0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(tv[i].v, tv[i].m, tv[i].a, tv[i].b, tv[i].s);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d_abort", i), 32'(pack_abort), 32'(tv[i].ea));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tv[i].ed));
        chk($sformatf("vec%0d_mode", i), 32'(out_mode), 32'(tv[i].em));
      end
    end
    step(1'b1, 2'd0, 4'h1, 4'h2, 1'b0);
    chk("bp_first_data", 32'(out_data), 32'h0012);
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 2'd0; in1 = 4'h3; in2 = 4'h4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", i), 32'(out_data), 32'h0012);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 2'd0, 4'h3, 4'h4, 1'b0);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'h0034);
    step(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    step(1'b1, 2'd3, 4'h1, 4'h0, 1'b0);
    step(1'b1, 2'd3, 4'h2, 4'h0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    chk("rst_mid_pack_abort", 32'(pack_abort), 32'd0);
    chk("rst_mid_pack_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 2'd3, 4'h9, 4'h0, 1'b0);
    chk("fresh_b1_abort", 32'(pack_abort), 32'd0);
    step(1'b1, 2'd3, 4'hA, 4'h0, 1'b0);
    step(1'b1, 2'd3, 4'hB, 4'h0, 1'b0);
    chk("fresh_b3_valid", 32'(out_valid), 32'd0);
    step(1'b1, 2'd3, 4'hC, 4'h0, 1'b0);
    chk("fresh_b4_valid", 32'(out_valid), 32'd1);
    chk("fresh_b4_data", 32'(out_data), 32'h9ABC);
    chk("fresh_b4_mode", 32'(out_mode), 32'd3);
    step(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
